// File: rtl/vga_layer_compositor.sv
// VGA raster engine: pixel divider, h/v counters, sync pulses and a
// fixed-priority layer compositor with test-pattern and frame tick.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   layer_hit         per-layer coverage of pixel (x, y), combinational
//   layer_color       layer i colour {R,G,B} at [i*3*CW +: 3*CW]
//   layer_enable      per-layer mask, masked layers never win
//   bg_color          colour of visible pixels with no winning layer
//   test_pattern      1: eight vertical colour bars replace compositing
//   x, y, visible     combinational position from the counters
//   pix_en            one-clk strobe per pixel
//   frame_tick        one-clk pulse on the last pixel of each frame
//   HSync, VSync      registered sync outputs
//   Red, Green, Blue  registered pixel colour
module vga_layer_compositor #(
  parameter int PIX_DIV          = 2,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int H_VISIBLE        = 640,
  parameter int H_FRONT          = 16,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int V_VISIBLE        = 480,
  parameter int V_FRONT          = 10,
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int NUM_LAYERS       = 4,
  parameter int CW               = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_LAYERS-1:0]      layer_hit,
  input  logic [NUM_LAYERS*3*CW-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]      layer_enable,
  input  logic [3*CW-1:0]            bg_color,
  input  logic                       test_pattern,
  output logic [9:0]                 x,
  output logic [9:0]                 y,
  output logic                       visible,
  output logic                       pix_en,
  output logic                       frame_tick,
  output logic                       HSync,
  output logic                       VSync,
  output logic [CW-1:0]              Red,
  output logic [CW-1:0]              Green,
  output logic [CW-1:0]              Blue
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNCE = 10'(H_SYNC);
  localparam logic [9:0] V_SYNCE = 10'(V_SYNC);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [12:0] H_VIS13 = 13'(H_VISIBLE);

  localparam logic SYNC_ON   = (SYNC_ACTIVE_HIGH != 0);
  localparam logic SYNC_IDLE = ~SYNC_ON;

  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [9:0]      hcount_q, hcount_d;
  logic [9:0]      vcount_q, vcount_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic [3*CW-1:0] rgb_q, rgb_d;

  logic            h_vis, v_vis;
  logic            h_wrap, v_wrap;
  logic [2:0]      bar;
  logic            win_found;
  logic [3*CW-1:0] win_rgb;
  logic [3*CW-1:0] pix_rgb;

  // Pixel divider and raster counters
  assign pix_en = (div_cnt_q == DIV_LAST);
  assign h_wrap = (hcount_q == H_LAST);
  assign v_wrap = (vcount_q == V_LAST);

  always_comb begin
    div_cnt_d = pix_en ? '0 : div_cnt_q + 1'b1;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    if (pix_en) begin
      if (h_wrap) begin
        hcount_d = '0;
        vcount_d = v_wrap ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  // Visible window and position
  assign h_vis   = (hcount_q >= H_START) && (hcount_q < H_END);
  assign v_vis   = (vcount_q >= V_START) && (vcount_q < V_END);
  assign visible = h_vis && v_vis;
  assign x       = visible ? hcount_q - H_START : '0;
  assign y       = visible ? vcount_q - V_START : '0;

  // Reset suppresses the tick even though pix_en may still be high
  assign frame_tick = pix_en && h_wrap && v_wrap && !reset;

  // Lowest enabled index that hits wins
  always_comb begin
    win_found = 1'b0;
    win_rgb   = bg_color;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (!win_found && layer_hit[i] && layer_enable[i]) begin
        win_found = 1'b1;
        win_rgb   = layer_color[i*3*CW +: 3*CW];
      end
    end
  end

  // Bar index 0..7 across the visible width
  assign bar = 3'(({3'b000, x} << 3) / H_VIS13);

  always_comb begin
    pix_rgb = '0;
    if (visible) begin
      if (test_pattern) begin
        pix_rgb = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
      end else begin
        pix_rgb = win_rgb;
      end
    end
  end

  // Outputs latch one pixel behind the counters
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pix_en) begin
      hsync_d = (hcount_q < H_SYNCE) ~^ SYNC_ON;
      vsync_d = (vcount_q < V_SYNCE) ~^ SYNC_ON;
      rgb_d   = pix_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      hsync_q   <= SYNC_IDLE;
      vsync_q   <= SYNC_IDLE;
      rgb_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
    end
  end

  assign HSync = hsync_q;
  assign VSync = vsync_q;
  assign Red   = rgb_q[3*CW-1 -: CW];
  assign Green = rgb_q[2*CW-1 -: CW];
  assign Blue  = rgb_q[CW-1:0];

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Randomised bench for vga_layer_compositor on a shrunken raster,
// plus a second instance with inverted sync and no pixel divider.
module tb_vga_layer_compositor;

  localparam int PD = 2;
  localparam int HS = 4, HB = 3, HV = 16, HF = 2;
  localparam int VS = 2, VB = 2, VV = 8, VF = 1;
  localparam int NL = 4, CW = 4;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;
  localparam int FRAME = PD * HT * VT;
  localparam int NCYC = FRAME * 8 + 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NL-1:0]        layer_hit, layer_enable;
  logic [NL*3*CW-1:0]   layer_color;
  logic [3*CW-1:0]      bg_color;
  logic                 test_pattern;

  logic [9:0]    x, y, x_i, y_i;
  logic          visible, pix_en, frame_tick, HSync, VSync;
  logic          visible_i, pix_en_i, frame_tick_i, HSync_i, VSync_i;
  logic [CW-1:0] Red, Green, Blue, Red_i, Green_i, Blue_i;

  vga_layer_compositor #(
    .PIX_DIV(PD), .H_SYNC(HS), .H_BACK(HB), .H_VISIBLE(HV),
    .H_FRONT(HF), .V_SYNC(VS), .V_BACK(VB), .V_VISIBLE(VV),
    .V_FRONT(VF), .SYNC_ACTIVE_HIGH(1), .NUM_LAYERS(NL), .CW(CW)
  ) u_dut (
    .clk(clk), .reset(reset), .layer_hit(layer_hit),
    .layer_color(layer_color), .layer_enable(layer_enable),
    .bg_color(bg_color), .test_pattern(test_pattern),
    .x(x), .y(y), .visible(visible), .pix_en(pix_en),
    .frame_tick(frame_tick), .HSync(HSync), .VSync(VSync),
    .Red(Red), .Green(Green), .Blue(Blue)
  );

  vga_layer_compositor #(
    .PIX_DIV(1), .H_SYNC(HS), .H_BACK(HB), .H_VISIBLE(HV),
    .H_FRONT(HF), .V_SYNC(VS), .V_BACK(VB), .V_VISIBLE(VV),
    .V_FRONT(VF), .SYNC_ACTIVE_HIGH(0), .NUM_LAYERS(NL), .CW(CW)
  ) u_inv (
    .clk(clk), .reset(reset), .layer_hit(layer_hit),
    .layer_color(layer_color), .layer_enable(layer_enable),
    .bg_color(bg_color), .test_pattern(test_pattern),
    .x(x_i), .y(y_i), .visible(visible_i), .pix_en(pix_en_i),
    .frame_tick(frame_tick_i), .HSync(HSync_i), .VSync(VSync_i),
    .Red(Red_i), .Green(Green_i), .Blue(Blue_i)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc, last_tick, fidx, mode, frames;
  bit          rst_done;
  int          lx0[NL], lx1[NL], ly0[NL], ly1[NL];
  logic [11:0] lcol[NL];
  logic [11:0] exp_rgb;
  logic        exp_hs, exp_vs;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               tag, got, want, cyc);
    end
  endtask

  function automatic logic [NL-1:0] hits(int xx, int yy);
    logic [NL-1:0] r;
    for (int i = 0; i < NL; i++)
      r[i] = xx >= lx0[i] && xx <= lx1[i] &&
             yy >= ly0[i] && yy <= ly1[i];
    return r;
  endfunction

  // Painter's algorithm: draw highest index first, lower ones on top
  function automatic logic [11:0] ref_rgb(bit vis, int xx,
      logic [NL-1:0] h, logic [NL-1:0] en,
      logic [11:0] bg, logic tp);
    int b;
    logic [11:0] c;
    if (!vis) return 12'h000;
    if (tp) begin
      b = xx * 8 / HV;
      return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
    end
    c = bg;
    for (int i = NL - 1; i >= 0; i--)
      if (h[i] && en[i]) c = lcol[i];
    return c;
  endfunction

  task automatic empty_layers();
    for (int i = 0; i < NL; i++) begin
      lx0[i] = 1; lx1[i] = 0; ly0[i] = 1; ly1[i] = 0;
      lcol[i] = 12'h000;
    end
  endtask

  task automatic rand_layers();
    for (int i = 0; i < NL; i++) begin
      lx0[i] = $urandom_range(0, HV - 1);
      lx1[i] = lx0[i] + $urandom_range(0, 6);
      ly0[i] = $urandom_range(0, VV - 1);
      ly1[i] = ly0[i] + $urandom_range(0, 3);
      lcol[i] = 12'($urandom);
    end
  endtask

  task automatic new_frame();
    mode = fidx % 4;
    fidx++;
    test_pattern = 1'b0;
    layer_enable = '1;
    case (mode)
      0: begin
        rand_layers();
        layer_enable = NL'($urandom);
        bg_color = 12'($urandom);
      end
      1: begin
        empty_layers();
        lx0[1] = 3; lx1[1] = 7; ly0[1] = 5; ly1[1] = 5;
        lcol[1] = 12'hF00;
        bg_color = 12'h00F;
      end
      2: begin
        empty_layers();
        lx0[0] = 10; lx1[0] = 10; ly0[0] = 0; ly1[0] = VV - 1;
        lx0[2] = 10; lx1[2] = 10; ly0[2] = 0; ly1[2] = VV - 1;
        lcol[0] = 12'h0F0;
        lcol[2] = 12'hFFF;
        bg_color = 12'($urandom);
      end
      default: begin
        rand_layers();
        bg_color = 12'($urandom);
        test_pattern = 1'b1;
      end
    endcase
  endtask

  initial begin
    reset = 1'b1;
    layer_hit = '0;
    layer_color = '0;
    layer_enable = '0;
    bg_color = '0;
    test_pattern = 1'b0;
    fidx = 0;
    frames = 0;
    rst_done = 1'b0;
    empty_layers();
    repeat (3) @(posedge clk);
    @(negedge clk);
    cyc = 0;
    chk("rst_hsync", HSync, 1'b0);
    chk("rst_vsync", VSync, 1'b0);
    chk("rst_rgb", {Red, Green, Blue}, 12'h000);
    chk("rst_tick", frame_tick, 1'b0);
    chk("rst_pix_en", pix_en, 1'b0);
    chk("rst_xyv", {x, y, visible}, 21'd0);
    chk("rst_inv_hsync", HSync_i, 1'b1);
    chk("rst_inv_vsync", VSync_i, 1'b1);
    exp_rgb = 12'h000;
    exp_hs = 1'b0;
    exp_vs = 1'b0;
    last_tick = -1;

    for (int k = 0; k < NCYC; k++) begin
      int p, h, v, mx, my, ip, ih, iv;
      bit pe, vis, ft;
      reset = 1'b0;
      if (cyc % FRAME == 0) new_frame();
      p   = cyc / PD;
      h   = p % HT;
      v   = (p / HT) % VT;
      pe  = (cyc % PD) == PD - 1;
      vis = h >= HS + HB && h < HS + HB + HV &&
            v >= VS + VB && v < VS + VB + VV;
      mx  = vis ? h - (HS + HB) : 0;
      my  = vis ? v - (VS + VB) : 0;
      ft  = pe && h == HT - 1 && v == VT - 1;

      case (mode)
        0: begin
          if ($urandom % 5 == 0) layer_enable = NL'($urandom);
          if ($urandom % 11 == 0) bg_color = 12'($urandom);
          if ($urandom % 13 == 0) test_pattern = ($urandom % 4 == 0);
        end
        2: if ($urandom % 3 == 0) layer_enable[0] = ~layer_enable[0];
        3: if ($urandom % 7 == 0) bg_color = 12'($urandom);
        default: ;
      endcase
      layer_hit = hits(mx, my);
      for (int i = 0; i < NL; i++)
        layer_color[i*12 +: 12] = lcol[i];

      chk("pix_en", pix_en, pe);
      chk("x", x, mx);
      chk("y", y, my);
      chk("visible", visible, vis);
      chk("frame_tick", frame_tick, ft);
      chk("hsync", HSync, exp_hs);
      chk("vsync", VSync, exp_vs);
      chk("rgb", {Red, Green, Blue}, exp_rgb);

      // No divider: sync reflects the pixel one clk earlier
      ip = cyc - 1;
      ih = (ip >= 0) ? ip % HT : 0;
      iv = (ip >= 0) ? (ip / HT) % VT : VS;
      chk("inv_pix_en", pix_en_i, 1'b1);
      chk("inv_hsync", HSync_i, (cyc == 0) ? 1'b1 : !(ih < HS));
      chk("inv_vsync", VSync_i, (cyc == 0) ? 1'b1 : !(iv < VS));

      if (frame_tick === 1'b1) begin
        chk("tick_gap", k - last_tick, FRAME);
        last_tick = k;
      end
      if (ft) frames++;

      if (!rst_done && frames == 2 && h == 12 && v == 6 && !pe) begin
        reset = 1'b1;
        rst_done = 1'b1;
      end

      if (reset) begin
        exp_rgb = 12'h000;
        exp_hs = 1'b0;
        exp_vs = 1'b0;
      end else if (pe) begin
        exp_rgb = ref_rgb(vis, mx, layer_hit, layer_enable,
                          bg_color, test_pattern);
        exp_hs = h < HS;
        exp_vs = v < VS;
      end

      @(posedge clk);
      if (reset) begin
        cyc = 0;
        last_tick = k;
      end else begin
        cyc++;
      end
      @(negedge clk);
    end

    chk("mid_reset_seen", rst_done, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_layer_compositor.md
# vga_layer_compositor

Parametrised VGA raster engine that replaces the fixed 640x480 controller in the display path. It divides the system clock into a pixel enable, runs the horizontal/vertical counters, and emits sync pulses with configurable timing and polarity. Each pixel it merges NUM_LAYERS object generators (planet, ship, asteroids, ...) by fixed priority over a background colour, and produces a per-frame tick for object motion.

## Interface
Parameters:
- PIX_DIV, 2 — clk cycles per pixel (≥1); 50 MHz gives 25 MHz pixels
- H_SYNC, 96 / H_BACK, 48 / H_VISIBLE, 640 / H_FRONT, 16 — horizontal segment lengths in pixels, in that order from hcount 0
- V_SYNC, 2 / V_BACK, 33 / V_VISIBLE, 480 / V_FRONT, 10 — vertical segment lengths in lines, same order
- SYNC_ACTIVE_HIGH, 1 — 1: HSync/VSync high during the sync segment; 0: low
- NUM_LAYERS, 4 — object layers (1..8)
- CW, 4 — bits per colour channel

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- layer_hit  in  NUM_LAYERS  bit i high = layer i covers pixel (x, y); combinational from x/y
- layer_color  in  NUM_LAYERS*3*CW  layer i colour {R,G,B} at bits [i*3*CW +: 3*CW]
- layer_enable  in  NUM_LAYERS  per-layer mask; a masked layer never wins
- bg_color  in  3*CW  colour of visible pixels with no winning layer
- test_pattern  in  1  1: 8 vertical colour bars replace compositing
- x  out  10  visible column, 0..H_VISIBLE-1; 0 outside visible
- y  out  10  visible row, 0..V_VISIBLE-1; 0 outside visible
- visible  out  1  current counters inside the visible window
- pix_en  out  1  one-clk strobe per pixel
- frame_tick  out  1  one-clk pulse per frame
- HSync, VSync  out  1 each  sync outputs, registered
- Red, Green, Blue  out  CW each  pixel colour, registered

## Operation
- Divider: div_cnt counts 0..PIX_DIV-1; pix_en = (div_cnt == PIX_DIV-1). With PIX_DIV=1, pix_en is constant 1.
- H_TOTAL is the sum of the H segments (800 by default); V_TOTAL is the sum of the V segments (525 by default).
- Counters advance only on pix_en.
  - hcount wraps H_TOTAL-1 -> 0.
  - vcount increments when hcount wraps, and wraps V_TOTAL-1 -> 0.
- H_START = H_SYNC+H_BACK (144); V_START = V_SYNC+V_BACK (35).
- visible is high when hcount is in [H_START, H_START+H_VISIBLE-1] and vcount is in [V_START, V_START+V_VISIBLE-1].
- x = hcount-H_START and y = vcount-V_START when visible; both are 0 otherwise. Counters are 10-bit, so H_TOTAL and V_TOTAL must each be ≤ 1024.
- Sync: sync segment is hcount < H_SYNC / vcount < V_SYNC. Output level = segment XNOR SYNC_ACTIVE_HIGH.
- Compositing (test_pattern=0): winner is the lowest index i with layer_hit[i] & layer_enable[i]. Colour is the winner's colour; if there is no winner, colour is bg_color.
- Test pattern (test_pattern=1): bar = x*8/H_VISIBLE (0..7). Red = {CW{bar[2]}}, Green = {CW{bar[1]}}, Blue = {CW{bar[0]}}.
- Blanking: when visible=0, RGB is forced to 0 regardless of mode.
- frame_tick: asserted for exactly one clk, on the clk where pix_en is high with hcount=H_TOTAL-1 and vcount=V_TOTAL-1.

## Timing
- Reset values:
  - div_cnt, hcount, vcount = 0
  - RGB = 0, frame_tick = 0
  - HSync/VSync = inactive level (0 when SYNC_ACTIVE_HIGH=1)
  - x, y, visible follow the counters, so x=0, y=0, visible=0
- Reset mid-frame takes effect on the next clk edge and overrides pix_en. The first pix_en after reset release occurs PIX_DIV clks later.
- x, y and visible are combinational from the counters. Layers must return hit/colour within the same clk.
- HSync, VSync and RGB register on pix_en from the current counters and layer inputs. They therefore lag the counters by exactly one pixel and are mutually aligned. They hold between pix_en strobes.
- layer_enable, bg_color and test_pattern are sampled on each pix_en. A change mid-line affects the next output pixel only.
- Simultaneous hits resolve by index in the same pixel, with no extra latency.

## Test plan
- Reset, then defaults, one frame: HSync high for exactly 96 pixels (192 clk) of every 800-pixel line; VSync high for 2 lines out of 525; frame_tick period = 840000 clk.
- SYNC_ACTIVE_HIGH=0: sync levels are inverted; during reset HSync=VSync=1.
- Layer 1 hit over x∈[100,109], y=50, colour 0xF00; bg 0x00F: RGB=F,0,0 for exactly 10 pixels on row 50, and 0,0,F elsewhere in visible, one pixel after the corresponding counters.
- Layers 0 and 2 both hit at x=200 with colours 0x0F0 and 0xFFF: output 0x0F0. With layer_enable[0]=0, output 0xFFF.
- test_pattern=1: x=0 gives RGB 0,0,0; x=80 gives 0,0,F; x=639 gives F,F,F; RGB=0 during blanking (hcount<144).
- Assert reset at hcount=400, vcount=300 for one clk: the next pixel shows counters 0/0; the first frame_tick follows exactly 840000 clk after reset release.
